// File: rtl/mont_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mont_exp_ctrl
// Brief    : Left-to-right square-and-multiply sequencer driving mont_mul.
// Revision : 1.0 - initial release
// ============================================================================
module mont_exp_ctrl #(
    parameter int WORDS     = 4,
    parameter int EXP_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_bits,
    input  logic [31:0] e_addr,
    input  logic [31:0] x_addr,
    input  logic [31:0] n_addr,
    input  logic [31:0] r_addr,
    output logic        mm_start,
    input  logic        mm_done,
    output logic [31:0] mm_a_addr,
    output logic [31:0] mm_b_addr,
    output logic [31:0] mm_n_addr,
    output logic [31:0] mm_r_addr,
    output logic        lsu_sel,
    output logic        lsu_ren,
    output logic [31:0] lsu_addr,
    input  logic        lsu_done,
    input  logic [31:0] lsu_rdata,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] mul_count
);

    localparam logic [15:0] C_EXP_MAX = 16'(EXP_WORDS * 32);

    // WORDS sizes the mont_mul operands; the sequencer itself never steps by it.
    if (WORDS < 1) begin : g_words_invalid
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_E   = 3'd1,
        S_SQR_ISSUE = 3'd2,
        S_SQR_WAIT  = 3'd3,
        S_MUL_ISSUE = 3'd4,
        S_MUL_WAIT  = 3'd5,
        S_NEXT      = 3'd6,
        S_FINISH    = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_k;
    logic [15:0] r_mul_count;
    logic [31:0] r_e_addr;
    logic [31:0] r_x_addr;
    logic [31:0] r_n_addr;
    logic [31:0] r_r_addr;
    logic [31:0] r_e_word;
    logic        r_abort_pend;
    logic        r_done;
    logic        r_aborted;
    logic [15:0] w_bits;
    logic        w_ebit;
    logic        w_abort_wait;

    assign w_bits       = (exp_bits > C_EXP_MAX) ? C_EXP_MAX : exp_bits;
    assign w_ebit       = r_e_word[r_k[4:0]];
    assign w_abort_wait = abort | r_abort_pend;

    always_comb begin
        w_next    = r_state;
        mm_start  = 1'b0;
        lsu_ren   = 1'b0;
        lsu_addr  = 32'd0;
        lsu_sel   = 1'b0;
        mm_b_addr = r_r_addr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_bits == 16'd0) ? S_FINISH : S_FETCH_E;
                end
            end
            S_FETCH_E: begin
                lsu_ren  = ~lsu_done;
                lsu_addr = r_e_addr + {19'd0, r_k[15:5], 2'b00};
                if (abort) begin
                    w_next = S_IDLE;
                end else if (lsu_done) begin
                    w_next = S_SQR_ISSUE;
                end
            end
            S_SQR_ISSUE: begin
                mm_start = ~abort;
                w_next   = abort ? S_IDLE : S_SQR_WAIT;
            end
            S_SQR_WAIT: begin
                lsu_sel = 1'b1;
                if (mm_done) begin
                    if (w_abort_wait) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = w_ebit ? S_MUL_ISSUE : S_NEXT;
                    end
                end
            end
            S_MUL_ISSUE: begin
                mm_b_addr = r_x_addr;
                mm_start  = ~abort;
                w_next    = abort ? S_IDLE : S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                lsu_sel   = 1'b1;
                mm_b_addr = r_x_addr;
                if (mm_done) begin
                    w_next = w_abort_wait ? S_IDLE : S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_k == 16'd0) begin
                    w_next = S_FINISH;
                end else begin
                    // k[4:0] wrapping to 31 means the next bit lives in a fresh word
                    w_next = (r_k[4:0] == 5'd0) ? S_FETCH_E : S_SQR_ISSUE;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k          <= 16'd0;
            r_mul_count  <= 16'd0;
            r_e_addr     <= 32'd0;
            r_x_addr     <= 32'd0;
            r_n_addr     <= 32'd0;
            r_r_addr     <= 32'd0;
            r_e_word     <= 32'd0;
            r_abort_pend <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_done    <= (r_state == S_FINISH);
            // any return to IDLE that does not come through FINISH is an abort
            r_aborted <= (w_next == S_IDLE) && (r_state != S_IDLE) && (r_state != S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_e_addr     <= e_addr;
                        r_x_addr     <= x_addr;
                        r_n_addr     <= n_addr;
                        r_r_addr     <= r_addr;
                        r_k          <= w_bits - 16'd1;
                        r_mul_count  <= 16'd0;
                        r_abort_pend <= 1'b0;
                    end
                end
                S_FETCH_E: begin
                    if (lsu_done && !abort) begin
                        r_e_word <= lsu_rdata;
                    end
                end
                S_SQR_ISSUE, S_MUL_ISSUE: begin
                    if (!abort) begin
                        r_mul_count <= r_mul_count + 16'd1;
                    end
                end
                S_SQR_WAIT, S_MUL_WAIT: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!abort && (r_k != 16'd0)) begin
                        r_k <= r_k - 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mm_a_addr = r_r_addr;
    assign mm_r_addr = r_r_addr;
    assign mm_n_addr = r_n_addr;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign mul_count = r_mul_count;

endmodule
`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mont_exp_ctrl
// Brief    : Scoreboard bench for mont_exp_ctrl with mont_mul and LSU models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mont_exp_ctrl;

    localparam logic [31:0] E_A = 32'h0000_1000;
    localparam logic [31:0] X_A = 32'h0000_2000;
    localparam logic [31:0] N_A = 32'h0000_3000;
    localparam logic [31:0] R_A = 32'h0000_4000;
    localparam int K_MM   = 0;
    localparam int K_LSU  = 1;
    localparam int K_DONE = 2;
    localparam int K_ABRT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] exp_bits;
    logic [31:0] e_addr, x_addr, n_addr, r_addr;
    logic        mm_start;
    logic        mm_done;
    logic        mm_done_m, mm_done_s;
    logic [31:0] mm_a_addr, mm_b_addr, mm_n_addr, mm_r_addr;
    logic        lsu_sel, lsu_ren, lsu_done;
    logic [31:0] lsu_addr, lsu_rdata;
    logic        busy, done, aborted;
    logic [15:0] mul_count;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] ew [4];
    int          mm_lat;
    int          n_checks = 0;
    int          n_fails  = 0;
    logic        prev_ren = 1'b0;
    logic [31:0] lsu_a;

    assign mm_done = mm_done_m | mm_done_s;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.WORDS(4), .EXP_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_bits(exp_bits),
        .e_addr(e_addr), .x_addr(x_addr), .n_addr(n_addr), .r_addr(r_addr),
        .mm_start(mm_start), .mm_done(mm_done),
        .mm_a_addr(mm_a_addr), .mm_b_addr(mm_b_addr), .mm_n_addr(mm_n_addr), .mm_r_addr(mm_r_addr),
        .lsu_sel(lsu_sel), .lsu_ren(lsu_ren), .lsu_addr(lsu_addr),
        .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .busy(busy), .done(done), .aborted(aborted), .mul_count(mul_count)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic observe(string name, int kind, logic [31:0] val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL %s: unexpected event value %h, nothing expected", name, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_fails++;
                $display("FAIL %s: got kind %0d value %h, expected kind %0d value %h",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    function automatic logic [31:0] e_lookup(logic [31:0] a);
        if (a >= E_A && a < E_A + 32'd16 && a[1:0] == 2'b00) return ew[(a - E_A) >> 2];
        return 32'hBAD0_BAD0;
    endfunction

    // Expected event stream for a complete run of the given length.
    task automatic push_run(int bits, int count);
        int nb;
        nb = (bits > 128) ? 128 : bits;
        for (int k = nb - 1; k >= 0; k--) begin
            if (k == nb - 1 || k % 32 == 31) exp_q.push_back('{K_LSU, E_A + 32'(4 * (k / 32))});
            exp_q.push_back('{K_MM, R_A});
            if (ew[k / 32][k % 32]) exp_q.push_back('{K_MM, X_A});
        end
        exp_q.push_back('{K_DONE, 32'(count)});
    endtask

    task automatic do_start(logic [15:0] bits);
        @(posedge clk); #2;
        exp_bits = bits; e_addr = E_A; x_addr = X_A; n_addr = N_A; r_addr = R_A;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_end(string name, int budget);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(done || aborted) && i < budget);
        check({name, "_end"}, {31'd0, done | aborted}, 32'd1);
        repeat (4) @(negedge clk);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_mm_start"}, {31'd0, mm_start}, 32'd0);
        check({tag, "_lsu_ren"}, {31'd0, lsu_ren}, 32'd0);
        check({tag, "_lsu_sel"}, {31'd0, lsu_sel}, 32'd0);
        check({tag, "_lsu_addr"}, lsu_addr, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
        check({tag, "_mul_count"}, {16'd0, mul_count}, 32'd0);
        check({tag, "_mm_a"}, mm_a_addr, 32'd0);
        check({tag, "_mm_b"}, mm_b_addr, 32'd0);
        check({tag, "_mm_n"}, mm_n_addr, 32'd0);
        check({tag, "_mm_r"}, mm_r_addr, 32'd0);
    endtask

    // mont_mul model: completion pulse mm_lat cycles after each start
    initial begin
        mm_done_m = 1'b0;
        forever begin
            @(negedge clk);
            if (mm_start) begin
                repeat (mm_lat) @(posedge clk);
                #2 mm_done_m = 1'b1;
                @(posedge clk); #2 mm_done_m = 1'b0;
            end
        end
    end

    // LSU model: answers a read one cycle after it is first seen
    initial begin
        lsu_done = 1'b0;
        lsu_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (lsu_ren && rst_n) begin
                lsu_a = lsu_addr;
                @(posedge clk); #2;
                lsu_done = 1'b1;
                lsu_rdata = e_lookup(lsu_a);
                @(posedge clk); #2;
                lsu_done = 1'b0;
                lsu_rdata = 32'd0;
            end
        end
    end

    // Monitor: every DUT event is matched against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ren = 1'b0;
            end else begin
                if (mm_start) begin
                    observe("mm_start_b_addr", K_MM, mm_b_addr);
                    check("mm_a_addr", mm_a_addr, R_A);
                    check("mm_r_addr", mm_r_addr, R_A);
                    check("mm_n_addr", mm_n_addr, N_A);
                end
                if (lsu_ren && !prev_ren) observe("lsu_read", K_LSU, lsu_addr);
                if (done) observe("done", K_DONE, {16'd0, mul_count});
                if (aborted) observe("aborted", K_ABRT, {16'd0, mul_count});
                if (mm_done_m && busy) check("lsu_sel_wait", {31'd0, lsu_sel}, 32'd1);
                prev_ren = lsu_ren;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int i;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_bits = 16'd0;
        e_addr = 32'd0; x_addr = 32'd0; n_addr = 32'd0; r_addr = 32'd0;
        mm_done_s = 1'b0; mm_lat = 2;
        for (int w = 0; w < 4; w++) ew[w] = 32'd0;
        repeat (3) @(negedge clk);
        check_reset("por");
        @(posedge clk); #2 rst_n = 1'b1;

        // 4-bit exponent 1011b
        ew[0] = 32'hB;
        exp_q.push_back('{K_LSU, E_A});
        exp_q.push_back('{K_MM, R_A}); exp_q.push_back('{K_MM, X_A});
        exp_q.push_back('{K_MM, R_A});
        exp_q.push_back('{K_MM, R_A}); exp_q.push_back('{K_MM, X_A});
        exp_q.push_back('{K_MM, R_A}); exp_q.push_back('{K_MM, X_A});
        exp_q.push_back('{K_DONE, 32'd7});
        do_start(16'd4);
        wait_end("b1011", 200);

        // zero-length exponent: immediate done
        exp_q.push_back('{K_DONE, 32'd0});
        @(posedge clk); #2;
        exp_bits = 16'd0; e_addr = E_A; x_addr = X_A; n_addr = N_A; r_addr = R_A;
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        check("zero_busy", {31'd0, busy}, 32'd1);
        check("zero_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_mul_count", {16'd0, mul_count}, 32'd0);
        repeat (4) @(negedge clk);
        check("zero_queue_empty", 32'(exp_q.size()), 32'd0);

        // 40 bits spanning two words
        ew[0] = 32'h0000_0001; ew[1] = 32'h0000_0080;
        push_run(40, 42);
        do_start(16'd40);
        wait_end("bits40", 2000);
        check("bits40_mul_count", {16'd0, mul_count}, 32'd42);

        // oversize exponent clamps to 128 bits
        ew[0] = 32'd0; ew[1] = 32'd0; ew[2] = 32'd0; ew[3] = 32'h8000_0000;
        push_run(128, 129);
        do_start(16'd200);
        wait_end("clamp", 5000);
        check("clamp_mul_count", {16'd0, mul_count}, 32'd129);

        // abort during SQR_WAIT, mont_mul finishes 10 cycles later
        mm_lat = 10;
        ew[0] = 32'hB; ew[1] = 32'd0; ew[2] = 32'd0; ew[3] = 32'd0;
        exp_q.push_back('{K_LSU, E_A});
        exp_q.push_back('{K_MM, R_A});
        exp_q.push_back('{K_ABRT, 32'd1});
        do_start(16'd4);
        i = 0;
        while (!mm_start && i < 50) begin @(negedge clk); i++; end
        @(posedge clk); #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        i = 0;
        while (!mm_done && i < 50) begin @(negedge clk); i++; end
        check("abort_wait_seen_done", {31'd0, mm_done}, 32'd1);
        check("abort_still_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("abort_pulse", {31'd0, aborted}, 32'd1);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // start during MUL_WAIT and spurious mm_done during FETCH_E are ignored
        mm_lat = 3;
        exp_q.push_back('{K_LSU, E_A});
        exp_q.push_back('{K_MM, R_A}); exp_q.push_back('{K_MM, X_A});
        exp_q.push_back('{K_MM, R_A});
        exp_q.push_back('{K_MM, R_A}); exp_q.push_back('{K_MM, X_A});
        exp_q.push_back('{K_MM, R_A}); exp_q.push_back('{K_MM, X_A});
        exp_q.push_back('{K_DONE, 32'd7});
        do_start(16'd4);
        i = 0;
        while (!lsu_ren && i < 20) begin @(negedge clk); i++; end
        @(posedge clk); #2 mm_done_s = 1'b1;
        @(posedge clk); #2 mm_done_s = 1'b0;
        i = 0;
        while (!(lsu_sel && mm_b_addr == X_A) && i < 100) begin @(negedge clk); i++; end
        @(posedge clk); #2 exp_bits = 16'd0; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_end("ignore", 300);

        // reset in MUL_WAIT, then a fresh 1-bit run
        exp_q.push_back('{K_LSU, E_A});
        exp_q.push_back('{K_MM, R_A}); exp_q.push_back('{K_MM, X_A});
        do_start(16'd4);
        i = 0;
        while (!(lsu_sel && mm_b_addr == X_A) && i < 100) begin @(negedge clk); i++; end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check_reset("midrst");
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        ew[0] = 32'd1;
        push_run(1, 2);
        do_start(16'd1);
        wait_end("after_rst", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
